ifetch_unit: RTL

- Instruction fetch stage directly upstream of the main control decoder.
- Owns the PC, issues single-outstanding requests to instruction memory, and buffers returned words in a 2-entry FIFO.
- Presents instructions to decode over a valid/ready handshake, with op split out for the decoder.
- Accepts PC redirects (branch/jump) from decode and flushes wrong-path work.

---
 rtl/ifetch_pkg.sv | 32 +++
 rtl/ifetch_buf.sv | 77 +++++++
 rtl/ifetch_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module : ifetch_pkg
// Desc   : Shared constants, FSM encoding and buffer entry layout for ifetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_W          = 32;
    localparam int          OP_W             = 6;
    localparam int          OP_MSB           = 31;
    localparam int          OP_LSB           = 26;

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
    } buf_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_buf.sv
// ============================================================================
// Module : ifetch_buf
// Desc   : Two-entry fetch FIFO; the head entry is its own register so the
//          decode-facing outputs come straight from flops.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_buf
    import ifetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  buf_entry_t push_entry,
    input  logic       pop,
    input  logic       flush,
    output logic       full,
    output logic       empty,
    output buf_entry_t head
);

    logic       r_head_v;
    logic       r_tail_v;
    buf_entry_t r_head;
    buf_entry_t r_tail;
    logic       w_pop;

    assign w_pop = pop & r_head_v;
    assign full  = r_head_v & r_tail_v;
    assign empty = ~r_head_v;
    assign head  = r_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_v <= 1'b0;
            r_tail_v <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
        end else if (flush) begin
            r_head_v <= 1'b0;
            r_tail_v <= 1'b0;
        end else begin
            case ({push, w_pop})
                2'b11: begin
                    // Head always refills from the older tail before the new word.
                    if (r_tail_v) begin
                        r_head <= r_tail;
                        r_tail <= push_entry;
                    end else begin
                        r_head <= push_entry;
                    end
                end
                2'b01: begin
                    if (r_tail_v) begin
                        r_head <= r_tail;
                    end
                    r_head_v <= r_tail_v;
                    r_tail_v <= 1'b0;
                end
                2'b10: begin
                    if (!r_head_v) begin
                        r_head   <= push_entry;
                        r_head_v <= 1'b1;
                    end else begin
                        r_tail   <= push_entry;
                        r_tail_v <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module : ifetch_unit
// Desc   : Instruction fetch stage: PC, single-outstanding imem requests and a
//          2-entry buffer toward decode. IFETCH_PERF_EN adds perf counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [OP_W-1:0]    id_op,
    output logic [31:0]        id_pc4
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_redirect_cnt
`endif
);

    localparam logic [31:0] c_pc_step = 32'd4;
    localparam logic [1:0]  c_depth   = 2'(BUF_DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_req_addr;
    logic [31:0]  w_req_addr_nxt;
    logic         r_discard;
    logic         w_discard_nxt;
    logic         w_push;
    logic         w_pop;
    logic         w_buf_full;
    logic         w_buf_empty;
    logic [1:0]   w_occupancy;
    logic         w_slot_free;
    logic [31:0]  w_pc_plus4;
    buf_entry_t   w_push_entry;
    buf_entry_t   w_head;

    assign w_occupancy  = {w_buf_full, ~w_buf_empty & ~w_buf_full};
    assign w_slot_free  = (c_depth - w_occupancy) != 2'd0;
    assign w_pc_plus4   = r_pc + c_pc_step;
    assign w_push_entry = '{instr: imem_rdata, pc4: w_pc_plus4};
    assign w_pop        = id_valid & id_ready;

    // The address is latched at issue so a redirect during WAIT cannot move it.
    assign imem_addr = (r_state == ST_WAIT) ? r_req_addr : r_pc;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_discard_nxt  = r_discard;
        w_push         = 1'b0;
        imem_req       = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (rst_n && w_slot_free && !redirect_valid) begin
                    imem_req       = 1'b1;
                    w_req_addr_nxt = r_pc;
                    w_state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_state_nxt   = ST_REQ;
                    w_discard_nxt = 1'b0;
                    if (!r_discard && !redirect_valid) begin
                        w_push   = 1'b1;
                        w_pc_nxt = w_pc_plus4;
                    end
                end else if (redirect_valid) begin
                    w_discard_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_REQ;
        endcase
        if (redirect_valid) begin
            w_pc_nxt = word_align(redirect_pc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    ifetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .full       (w_buf_full),
        .empty      (w_buf_empty),
        .head       (w_head)
    );

    assign id_valid = ~w_buf_empty;
    assign id_instr = w_head.instr;
    assign id_pc4   = w_head.pc4;
    assign id_op    = w_head.instr[OP_MSB:OP_LSB];

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (!id_valid) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
